dma_copier: RTL and testbench

DMA_COPIER -- requirements
Module: dma_copier

---
 rtl/dma_copier.sv | 143 ++++++++++++++
 tb/tb_dma_copier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_copier.sv
// Single-channel word DMA: copies Len 32-bit words from SrcAddr to DstAddr over a simple strobe bus.
// Optional fill mode (writes a latched pattern, no reads) is enabled by defining DMA_FILL_EN.
module dma_copier #(
  parameter int LEN_W = 6
) (
  input  logic             C,
  input  logic             R,
  input  logic             Start,
  input  logic [31:0]      SrcAddr,
  input  logic [31:0]      DstAddr,
  input  logic [LEN_W-1:0] Len,
  input  logic             Mode,
  input  logic [31:0]      Pattern,
  output logic [31:0]      Addr,
  output logic             Read,
  output logic             Write,
  output logic [31:0]      WData,
  input  logic [31:0]      RData,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [1:0]       dbg_state
);

  // Bus handshake: a strobe (Read or Write) with Addr is a complete transfer in
  // that cycle; RData is valid combinationally while Read is high and the
  // responder commits a write on the edge that closes a Write cycle.

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nx;
  logic [31:0]      src, dst, data_buf;
  logic [LEN_W-1:0] cnt;
  logic             fill_req, fill_mode;
  logic [31:0]      wr_word;
  logic             unaligned;

`ifdef DMA_FILL_EN
  logic [31:0] pat;

  assign fill_req = Mode;
  assign wr_word  = fill_mode ? pat : data_buf;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      fill_mode <= 1'b0;
      pat       <= '0;
    end else if (state == IDLE && Start) begin
      fill_mode <= Mode;
      pat       <= Pattern;
    end
  end
`else
  logic unused_fill_inputs;

  assign fill_req           = 1'b0;
  assign fill_mode          = 1'b0;
  assign wr_word            = data_buf;
  assign unused_fill_inputs = ^{Mode, Pattern};
`endif

  // Source alignment does not matter when nothing is read.
  assign unaligned = (DstAddr[1:0] != 2'b00) || (!fill_req && (SrcAddr[1:0] != 2'b00));

  always_ff @(posedge C or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (unaligned || (Len == '0)) state_nx = DONE;
          else if (fill_req)            state_nx = WR;
          else                          state_nx = RD;
        end
      end
      RD:   state_nx = WR;
      WR: begin
        if (cnt == LEN_W'(1)) state_nx = DONE;
        else if (fill_mode)   state_nx = WR;
        else                  state_nx = RD;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      src      <= '0;
      dst      <= '0;
      cnt      <= '0;
      data_buf <= '0;
      Err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src <= SrcAddr;
            dst <= DstAddr;
            cnt <= Len;
            Err <= unaligned;
          end
        end
        RD: data_buf <= RData;
        WR: begin
          src <= src + 32'd4;
          dst <= dst + 32'd4;
          cnt <= cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from the state register alone, so reset clears them at once.
  always_comb begin
    Addr  = '0;
    Read  = 1'b0;
    Write = 1'b0;
    WData = '0;
    case (state)
      RD: begin
        Addr = src;
        Read = 1'b1;
      end
      WR: begin
        Addr  = dst;
        Write = 1'b1;
        WData = wr_word;
      end
      default: ;
    endcase
  end

  assign Busy      = (state == RD) || (state == WR);
  assign Done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dma_copier.sv
// Self-checking bench for dma_copier: table vectors, random transfers against a
// word-list reference model, plus restart-ignore and mid-transfer reset sequences.
module tb_dma_copier;

`ifdef DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam int LEN_W = 6;

  logic             C, R, Start, Mode;
  logic [31:0]      SrcAddr, DstAddr, Pattern, Addr, WData, RData;
  logic [LEN_W-1:0] Len;
  logic             Read, Write, Busy, Done, Err;
  logic [1:0]       dbg_state;

  dma_copier #(.LEN_W(LEN_W)) dut (
    .C(C), .R(R), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Len(Len), .Mode(Mode), .Pattern(Pattern), .Addr(Addr), .Read(Read),
    .Write(Write), .WData(WData), .RData(RData), .Busy(Busy), .Done(Done),
    .Err(Err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial C = 1'b0;
  always #5 C = ~C;

  // bus responder: 256-word RAM, address bits [9:2]
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  assign RData = mem[Addr[9:2]];
  always @(posedge C) if (Write) mem[Addr[9:2]] <= WData;

  // scoreboard: {err,busy,done,read,write,addr,wdata} per cycle
  localparam int W = 69;
  logic [W-1:0] exp_q[$];
  int vecs = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] pk(input logic e, b, d, rd, wr,
                                      input logic [31:0] a, wd);
    return {e, b, d, rd, wr, a, wd};
  endfunction

  function automatic logic [W-1:0] obs();
    return {Err, Busy, Done, Read, Write, Addr, WData};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, want);
    vecs++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        if (bad == 0) $display("FAIL %s: mem[%0d] got %h want %h", name, i, mem[i], ref_mem[i]);
        bad++;
      end
    vecs++;
    if (bad != 0) miscompares++;
  endtask

  // reference model: the transfer as an ordered list of bus cycles
  task automatic model(input logic [31:0] s, d, input int n, input logic m,
                       input logic [31:0] p, input logic e);
    logic fill;
    logic [31:0] a, b, w;
    fill = m && FILL_EN;
    exp_q.delete();
    if (!e && n != 0)
      for (int i = 0; i < n; i++) begin
        a = s + 32'(4 * i);
        b = d + 32'(4 * i);
        if (!fill) exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, 32'd0));
        w = fill ? p : ref_mem[a[9:2]];
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, b, w));
        ref_mem[b[9:2]] = w;
      end
    exp_q.push_back(pk(e, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    exp_q.push_back(pk(e, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
  endtask

  // driver: pulse Start at a negedge, then sample each following negedge
  task automatic run_xfer(input string name, input logic [31:0] s, d, input int n,
                          input logic m, input logic [31:0] p, input logic e);
    int cyc;
    model(s, d, n, m, p, e);
    @(negedge C);
    SrcAddr = s; DstAddr = d; Len = LEN_W'(n); Mode = m; Pattern = p; Start = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0) begin
      @(negedge C);
      Start = 1'b0;
      cyc++;
      check($sformatf("%s cyc%0d", name, cyc), obs(), exp_q.pop_front());
    end
    check_mem({name, " mem"});
  endtask

  typedef struct {
    logic [31:0] src, dst;
    int          len;
    logic        mode;
    logic [31:0] pat;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int bus, dn, dn_cyc;
    logic [31:0] s, d;
    int n;
    logic m, e;

    R = 1'b0; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0; Mode = 1'b0; Pattern = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;

    #2 check("reset outputs", obs(), '0);
    repeat (2) @(negedge C);
    R = 1'b1;

    tbl[0] = '{32'h0000_0000, 32'h0000_0040, 3, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0080, 0, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'h0000_0042, 2, 1'b0, 32'h0, 1'b1};
    tbl[3] = '{32'h0000_0004, 32'h0000_0084, 2, 1'b0, 32'h0, 1'b0};
    tbl[4] = '{32'h0000_0001, 32'h0000_0090, 2, 1'b0, 32'h0, 1'b1};
    tbl[5] = '{32'hFFFF_FFF8, 32'h0000_0200, 3, 1'b0, 32'h0, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0010, 2, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[7] = '{32'h0000_0003, 32'h0000_0020, 1, 1'b1, 32'h1234_5678, !FILL_EN};

    for (int i = 0; i < 8; i++)
      run_xfer($sformatf("tbl%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len,
               tbl[i].mode, tbl[i].pat, tbl[i].exp_err);

    check("copy word0", {37'd0, mem[16]}, {37'd0, 32'h11});
    check("copy word2", {37'd0, mem[18]}, {37'd0, 32'h33});

    // Start re-pulsed during a Len=4 copy must be ignored
    model(32'h100, 32'h180, 4, 1'b0, 32'h0, 1'b0);
    exp_q.delete();
    @(negedge C);
    SrcAddr = 32'h100; DstAddr = 32'h180; Len = LEN_W'(4); Mode = 1'b0; Start = 1'b1;
    bus = 0; dn = 0; dn_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge C);
      Start = (c == 2 || c == 5);
      if (Read || Write) bus++;
      if (Done) begin dn++; dn_cyc = c; end
    end
    Start = 1'b0;
    check("restart bus cycles", W'(bus), W'(8));
    check("restart done count", W'(dn), W'(1));
    check("restart done cycle", W'(dn_cyc), W'(9));
    check_mem("restart mem");

    // reset during the second WR of a Len=3 copy
    @(negedge C);
    SrcAddr = 32'h300; DstAddr = 32'h340; Len = LEN_W'(3); Start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge C);
      Start = 1'b0;
    end
    check("pre-abort WR", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h344, ref_mem[193]));
    ref_mem[208] = ref_mem[192];
    #1 R = 1'b0;
    #1 check("async reset", obs(), '0);
    @(negedge C);
    R = 1'b1;
    bus = 0;
    repeat (6) begin
      @(negedge C);
      if (Read || Write || Busy || Done) bus++;
    end
    check("no resume", W'(bus), W'(0));
    check_mem("abort mem");

    // random transfers
    for (int k = 0; k < 25; k++) begin
      s = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
      n = $urandom_range(0, 9);
      m = 1'($urandom_range(0, 1));
      e = (d[1:0] != 2'b00) || (!(m && FILL_EN) && s[1:0] != 2'b00);
      run_xfer($sformatf("rnd%0d", k), s, d, n, m, $urandom, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
